// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg: shared definitions for the register write-back queue.
//   WORD_SIZE   - register-file data width (16)
//   REG_ADDR_W  - register-address width (2)
//   wb_entry_t  - one queued write {addr, data}
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned REG_ADDR_W = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue: circular write queue (storage, head/tail pointers, entry count).
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   enq0_valid_i    - enqueue slot 0 (older of a same-cycle pair)
//   enq0_entry_i
//   enq1_valid_i    - enqueue slot 1 (younger of a same-cycle pair)
//   enq1_entry_i
//   deq_i           - pop the head entry this cycle
//   head_entry_o    - entry at the head pointer
//   head_ptr_o      - head pointer
//   count_o         - number of valid entries
//   mem_o           - raw storage, for associative lookups by the parent
// The parent guarantees enqueues never exceed the free space and that
// deq_i is only asserted while count_o != 0.
// ---------------------------------------------------------------------------
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq0_valid_i,
  input  wb_entry_t                    enq0_entry_i,
  input  logic                         enq1_valid_i,
  input  wb_entry_t                    enq1_entry_i,
  input  logic                         deq_i,
  output wb_entry_t                    head_entry_o,
  output logic [$clog2(WB_DEPTH)-1:0]  head_ptr_o,
  output logic [$clog2(WB_DEPTH):0]    count_o,
  output wb_entry_t [WB_DEPTH-1:0]     mem_o
);

  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t [WB_DEPTH-1:0] mem_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] enq1_ptr;

  // Power-of-two depth: pointer arithmetic wraps naturally.
  always_comb begin
    enq1_ptr = tail_q + PW'(enq0_valid_i);
    tail_d   = tail_q + PW'(enq0_valid_i) + PW'(enq1_valid_i);
    head_d   = head_q + PW'(deq_i);
    count_d  = count_q + CW'(enq0_valid_i) + CW'(enq1_valid_i) - CW'(deq_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq0_valid_i) mem_q[tail_q]   <= enq0_entry_i;
      if (enq1_valid_i) mem_q[enq1_ptr] <= enq1_entry_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign head_ptr_o   = head_q;
  assign count_o      = count_q;
  assign mem_o        = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback: queues load-result and ALU-result register writes and
// retires one per cycle into the register file's write port.
//   clk, reset                        - clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_data - load-result write request
//   alu_valid/alu_ready/alu_addr/alu_data - ALU-result write request
//   rf_write/rf_addr/rf_data          - register file write, addr3, data3
//   byp_addr1/byp_addr2               - register file read addresses
//   byp_hit1/byp_data1, byp_hit2/byp_data2 - pending-write bypass
//   pending                           - current queued entry count
// Build option: define WB_BYPASS_EN to enable the bypass lookup; otherwise
// the bypass outputs are tied to zero.
// ---------------------------------------------------------------------------
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [REG_ADDR_W-1:0]       ld_addr,
  input  logic [WORD_SIZE-1:0]        ld_data,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [REG_ADDR_W-1:0]       alu_addr,
  input  logic [WORD_SIZE-1:0]        alu_data,
  output logic                        rf_write,
  output logic [REG_ADDR_W-1:0]       rf_addr,
  output logic [WORD_SIZE-1:0]        rf_data,
  input  logic [REG_ADDR_W-1:0]       byp_addr1,
  input  logic [REG_ADDR_W-1:0]       byp_addr2,
  output logic                        byp_hit1,
  output logic [WORD_SIZE-1:0]        byp_data1,
  output logic                        byp_hit2,
  output logic [WORD_SIZE-1:0]        byp_data2,
  output logic [$clog2(WB_DEPTH):0]   pending
);

  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]            count;
  logic [CW-1:0]            free;
  logic [PW-1:0]            head;
  wb_entry_t                head_entry;
  wb_entry_t [WB_DEPTH-1:0] mem;
  logic                     ld_acc;
  logic                     alu_acc;

  // Readiness looks only at the registered count; a same-cycle dequeue is
  // not credited. Reset forces ready since the queue is being emptied.
  always_comb begin
    free      = CW'(WB_DEPTH) - count;
    ld_ready  = reset | (free >= CW'(1));
    alu_ready = reset | (free >= CW'(2)) | ((free >= CW'(1)) & ~ld_valid);
    ld_acc    = ld_valid & ld_ready;
    alu_acc   = alu_valid & alu_ready;
  end

  // ld goes in slot 0 so that a same-cycle ALU write is the younger entry.
  wb_queue #(
    .WB_DEPTH (WB_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .enq0_valid_i (ld_acc),
    .enq0_entry_i ('{addr: ld_addr, data: ld_data}),
    .enq1_valid_i (alu_acc),
    .enq1_entry_i ('{addr: alu_addr, data: alu_data}),
    .deq_i        (rf_write),
    .head_entry_o (head_entry),
    .head_ptr_o   (head),
    .count_o      (count),
    .mem_o        (mem)
  );

  always_comb begin
    rf_write = (count != '0);
    rf_addr  = rf_write ? head_entry.addr : '0;
    rf_data  = rf_write ? head_entry.data : '0;
  end

  assign pending = count;

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    idx       = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (mem[idx].addr == byp_addr1) begin
          byp_hit1  = 1'b1;
          byp_data1 = mem[idx].data;
        end
        if (mem[idx].addr == byp_addr2) begin
          byp_hit2  = 1'b1;
          byp_data2 = mem[idx].data;
        end
      end
    end
  end
`else
  logic unused_byp;

  assign unused_byp = ^{byp_addr1, byp_addr2, head, mem};
  assign byp_hit1   = 1'b0;
  assign byp_data1  = '0;
  assign byp_hit2   = 1'b0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
  import wb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_ready;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;
  logic        alu_valid, alu_ready;
  logic [1:0]  alu_addr;
  logic [15:0] alu_data;
  logic        rf_write;
  logic [1:0]  rf_addr;
  logic [15:0] rf_data;
  logic [1:0]  byp_addr1, byp_addr2;
  logic        byp_hit1, byp_hit2;
  logic [15:0] byp_data1, byp_data2;
  logic [2:0]  pending;

  int unsigned checks = 0;
  int unsigned errors = 0;

  reg_writeback #(.WB_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .rf_write  (rf_write),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [1:0] la, input logic [15:0] ldat,
                       input logic av, input logic [1:0] aa, input logic [15:0] adat);
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldat;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = adat;
    #1;
  endtask

  // Expected bypass result: zero unless the bypass build is selected.
  function automatic logic [31:0] bx(input logic [31:0] v);
    return BYP ? v : 32'h0;
  endfunction

  task automatic rf_expect(input string tag, input logic w, input logic [1:0] a,
                           input logic [15:0] d, input logic [2:0] p);
    check({tag, ".rf_write"}, 32'(rf_write), 32'(w));
    check({tag, ".rf_addr"},  32'(rf_addr),  32'(a));
    check({tag, ".rf_data"},  32'(rf_data),  32'(d));
    check({tag, ".pending"},  32'(pending),  32'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    byp_addr1 = 2'd0;
    byp_addr2 = 2'd0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    check("rst_ld_ready",  32'(ld_ready),  32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    rf_expect("after_rst", 1'b0, 2'd0, 16'h0, 3'd0);
    check("after_rst.byp_hit1",  32'(byp_hit1),  32'd0);
    check("after_rst.byp_data1", 32'(byp_data1), 32'd0);
    check("after_rst.byp_hit2",  32'(byp_hit2),  32'd0);
    check("idle_ld_ready",  32'(ld_ready),  32'd1);
    check("idle_alu_ready", 32'(alu_ready), 32'd1);

    // Single load write: visible the cycle after acceptance, then retired.
    byp_addr1 = 2'd2;
    drive(1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'h0);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    rf_expect("ld1", 1'b1, 2'd2, 16'h1234, 3'd1);
    check("ld1.byp_hit1",  32'(byp_hit1),  bx(32'd1));
    check("ld1.byp_data1", 32'(byp_data1), bx(32'h1234));
    tick();
    rf_expect("ld1_done", 1'b0, 2'd0, 16'h0, 3'd0);
    check("ld1_done.byp_hit1", 32'(byp_hit1), 32'd0);

    // Same-cycle ld and alu to one register: ld first, alu is youngest.
    byp_addr1 = 2'd1;
    drive(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 16'h5555);
    check("pair.ld_ready",  32'(ld_ready),  32'd1);
    check("pair.alu_ready", 32'(alu_ready), 32'd1);
    check("pair.byp_same_cycle", 32'(byp_hit1), 32'd0);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    rf_expect("pair0", 1'b1, 2'd1, 16'hAAAA, 3'd2);
    check("pair0.byp_hit1",  32'(byp_hit1),  bx(32'd1));
    check("pair0.byp_data1", 32'(byp_data1), bx(32'h5555));
    tick();
    rf_expect("pair1", 1'b1, 2'd1, 16'h5555, 3'd1);
    check("pair1.byp_data1", 32'(byp_data1), bx(32'h5555));
    tick();
    rf_expect("pair_done", 1'b0, 2'd0, 16'h0, 3'd0);

    // Sustained dual requests: count climbs to 3, then ALU is throttled.
    byp_addr1 = 2'd1;
    byp_addr2 = 2'd0;
    drive(1'b1, 2'd0, 16'h0A01, 1'b1, 2'd1, 16'h0B02);
    tick();
    rf_expect("fill_a", 1'b1, 2'd0, 16'h0A01, 3'd2);
    drive(1'b1, 2'd2, 16'h0C03, 1'b1, 2'd3, 16'h0D04);
    check("fill2.alu_ready", 32'(alu_ready), 32'd1);
    tick();
    rf_expect("fill_b", 1'b1, 2'd1, 16'h0B02, 3'd3);
    check("fill_b.byp_hit2_gone", 32'(byp_hit2), 32'd0);
    check("fill_b.byp_data1", 32'(byp_data1), bx(32'h0B02));
    drive(1'b1, 2'd0, 16'h0E05, 1'b1, 2'd1, 16'h0F06);
    check("p3.ld_ready",  32'(ld_ready),  32'd1);
    check("p3.alu_ready", 32'(alu_ready), 32'd0);
    tick();
    rf_expect("fill_c", 1'b1, 2'd2, 16'h0C03, 3'd3);
    drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 16'h0F06);
    check("p3_noload.alu_ready", 32'(alu_ready), 32'd1);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    rf_expect("drain_d", 1'b1, 2'd3, 16'h0D04, 3'd3);
    check("drain_d.byp_data1", 32'(byp_data1), bx(32'h0F06));
    check("drain_d.byp_hit2",  32'(byp_hit2),  bx(32'd1));
    check("drain_d.byp_data2", 32'(byp_data2), bx(32'h0E05));
    tick();
    rf_expect("drain_e", 1'b1, 2'd0, 16'h0E05, 3'd2);
    tick();
    rf_expect("drain_f", 1'b1, 2'd1, 16'h0F06, 3'd1);
    check("drain_f.byp_hit2", 32'(byp_hit2), 32'd0);
    tick();
    rf_expect("drain_done", 1'b0, 2'd0, 16'h0, 3'd0);

    // Reset with three entries queued and a request in the same cycle.
    drive(1'b1, 2'd3, 16'h1111, 1'b1, 2'd3, 16'h2222);
    tick();
    drive(1'b1, 2'd3, 16'h3333, 1'b1, 2'd3, 16'h4444);
    tick();
    check("pre_rst.pending", 32'(pending), 32'd3);
    byp_addr1 = 2'd3;
    byp_addr2 = 2'd3;
    reset = 1'b1;
    drive(1'b1, 2'd3, 16'h5555, 1'b0, 2'd0, 16'h0);
    check("in_rst.alu_ready", 32'(alu_ready), 32'd1);
    tick();
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    rf_expect("rst3", 1'b0, 2'd0, 16'h0, 3'd0);
    check("rst3.byp_hit1",  32'(byp_hit1),  32'd0);
    check("rst3.byp_hit2",  32'(byp_hit2),  32'd0);
    check("rst3.byp_data1", 32'(byp_data1), 32'd0);
    check("rst3.ld_ready",  32'(ld_ready),  32'd1);
    tick();
    rf_expect("rst3_quiet", 1'b0, 2'd0, 16'h0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
